// File: rtl/rv32i_enc_pkg.sv
// RV32I encoding definitions shared by the IMEM loader and its encoder:
// op mnemonics, instruction-format layouts and fixed field values.
package rv32i_enc_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } rv32i_op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} rv32i_fmt_e;

  typedef enum logic [1:0] {ST_LOAD, ST_SEAL_WR, ST_SEALED} loader_state_e;

  typedef struct packed {
    logic [6:0] funct7; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [4:0] rd;  logic [6:0] opcode;
  } r_fmt_t;
  typedef struct packed {
    logic [11:0] imm; logic [4:0] rs1; logic [2:0] funct3; logic [4:0] rd; logic [6:0] opcode;
  } i_fmt_t;
  typedef struct packed {
    logic [6:0] imm_hi; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [4:0] imm_lo; logic [6:0] opcode;
  } s_fmt_t;
  typedef struct packed {
    logic imm_12; logic [5:0] imm_10_5; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [3:0] imm_4_1; logic imm_11; logic [6:0] opcode;
  } b_fmt_t;
  typedef struct packed {
    logic [19:0] imm_31_12; logic [4:0] rd; logic [6:0] opcode;
  } u_fmt_t;
  typedef struct packed {
    logic imm_20; logic [9:0] imm_10_1; logic imm_11; logic [7:0] imm_19_12;
    logic [4:0] rd; logic [6:0] opcode;
  } j_fmt_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000, FUNCT3_SLL  = 3'b001, FUNCT3_SLT = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011, FUNCT3_XOR  = 3'b100, FUNCT3_SR  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110, FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000, FUNCT3_BNE  = 3'b001, FUNCT3_BLT = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101, FUNCT3_BLTU = 3'b110, FUNCT3_BGEU = 3'b111;
  localparam logic [2:0] FUNCT3_B    = 3'b000, FUNCT3_H    = 3'b001, FUNCT3_W   = 3'b010;
  localparam logic [2:0] FUNCT3_BU   = 3'b100, FUNCT3_HU   = 3'b101;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [1:0] ERR_NONE = 2'b00, ERR_OP = 2'b01, ERR_IMM = 2'b10;

  // JAL x0,0: spin in place once the image ends
  localparam logic [31:0] TERMINATOR = 32'h0000_006F;

  // True when v[31:msb] are all equal, i.e. v fits a signed field of msb+1 bits
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic all1, all0;
    all1 = 1'b1;
    all0 = 1'b1;
    for (int unsigned k = msb; k < 32; k++) begin
      all1 &= v[k];
      all0 &= ~v[k];
    end
    return all1 | all0;
  endfunction

endpackage

// File: rtl/rv32i_instr_encode.sv
// Combinational RV32I encoder: mnemonic plus register/immediate fields to a
// 32-bit instruction word, with op and immediate legality flags.
module rv32i_instr_encode
  import rv32i_enc_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_op_ok,
  output logic        o_imm_ok
);

  rv32i_fmt_e fmt;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  r_fmt_t r;
  i_fmt_t i, sh;
  s_fmt_t s;
  b_fmt_t b;
  u_fmt_t u;
  j_fmt_t j;

  always_comb begin
    fmt     = FMT_R;
    opc     = OPCODE_OP;
    f3      = FUNCT3_ADD;
    f7      = FUNCT7_BASE;
    o_op_ok = 1'b1;
    case (i_op)
      OP_LUI:   begin fmt = FMT_U; opc = OPCODE_LUI;   end
      OP_AUIPC: begin fmt = FMT_U; opc = OPCODE_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; opc = OPCODE_JAL;   end
      OP_JALR:  begin fmt = FMT_I; opc = OPCODE_JALR;  end
      OP_BEQ:   begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BNE;  end
      OP_BLT:   begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BLT;  end
      OP_BGE:   begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opc = OPCODE_BRANCH; f3 = FUNCT3_BGEU; end
      OP_LB:    begin fmt = FMT_I; opc = OPCODE_LOAD;   f3 = FUNCT3_B;    end
      OP_LH:    begin fmt = FMT_I; opc = OPCODE_LOAD;   f3 = FUNCT3_H;    end
      OP_LW:    begin fmt = FMT_I; opc = OPCODE_LOAD;   f3 = FUNCT3_W;    end
      OP_LBU:   begin fmt = FMT_I; opc = OPCODE_LOAD;   f3 = FUNCT3_BU;   end
      OP_LHU:   begin fmt = FMT_I; opc = OPCODE_LOAD;   f3 = FUNCT3_HU;   end
      OP_SB:    begin fmt = FMT_S; opc = OPCODE_STORE;  f3 = FUNCT3_B;    end
      OP_SH:    begin fmt = FMT_S; opc = OPCODE_STORE;  f3 = FUNCT3_H;    end
      OP_SW:    begin fmt = FMT_S; opc = OPCODE_STORE;  f3 = FUNCT3_W;    end
      OP_ADDI:  begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_SLTU; end
      OP_XORI:  begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_XOR;  end
      OP_ORI:   begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_OR;   end
      OP_ANDI:  begin fmt = FMT_I; opc = OPCODE_OP_IMM; f3 = FUNCT3_AND;  end
      OP_SLLI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SLL; end
      OP_SRLI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SR;  end
      OP_SRAI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SR; f7 = FUNCT7_ALT; end
      OP_ADD:   f3 = FUNCT3_ADD;
      OP_SUB:   begin f3 = FUNCT3_ADD; f7 = FUNCT7_ALT; end
      OP_SLL:   f3 = FUNCT3_SLL;
      OP_SLT:   f3 = FUNCT3_SLT;
      OP_SLTU:  f3 = FUNCT3_SLTU;
      OP_XOR:   f3 = FUNCT3_XOR;
      OP_SRL:   f3 = FUNCT3_SR;
      OP_SRA:   begin f3 = FUNCT3_SR; f7 = FUNCT7_ALT; end
      OP_OR:    f3 = FUNCT3_OR;
      OP_AND:   f3 = FUNCT3_AND;
      default:  o_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    r  = '{funct7: f7, rs2: i_rs2, rs1: i_rs1, funct3: f3, rd: i_rd, opcode: opc};
    i  = '{imm: i_imm[11:0], rs1: i_rs1, funct3: f3, rd: i_rd, opcode: opc};
    sh = '{imm: {f7, i_imm[4:0]}, rs1: i_rs1, funct3: f3, rd: i_rd, opcode: opc};
    s  = '{imm_hi: i_imm[11:5], rs2: i_rs2, rs1: i_rs1, funct3: f3,
           imm_lo: i_imm[4:0], opcode: opc};
    b  = '{imm_12: i_imm[12], imm_10_5: i_imm[10:5], rs2: i_rs2, rs1: i_rs1, funct3: f3,
           imm_4_1: i_imm[4:1], imm_11: i_imm[11], opcode: opc};
    u  = '{imm_31_12: i_imm[31:12], rd: i_rd, opcode: opc};
    j  = '{imm_20: i_imm[20], imm_10_1: i_imm[10:1], imm_11: i_imm[11],
           imm_19_12: i_imm[19:12], rd: i_rd, opcode: opc};
    o_word   = r;
    o_imm_ok = 1'b1;
    case (fmt)
      FMT_I:   begin o_word = i;  o_imm_ok = sext_fits(i_imm, 11); end
      FMT_SH:  begin o_word = sh; o_imm_ok = ~|i_imm[31:5]; end
      FMT_S:   begin o_word = s;  o_imm_ok = sext_fits(i_imm, 11); end
      FMT_B:   begin o_word = b;  o_imm_ok = sext_fits(i_imm, 12) & ~i_imm[0]; end
      FMT_U:   o_word = u;
      FMT_J:   begin o_word = j;  o_imm_ok = sext_fits(i_imm, 20) & ~i_imm[0]; end
      default: o_word = r;
    endcase
  end

endmodule

// File: rtl/rv32i_imem_loader.sv
// Handshaked RV32I image builder: encodes one request per cycle and writes it
// to an IMEM port at an auto-incrementing address; seal appends a terminator.
module rv32i_imem_loader
  import rv32i_enc_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned BASE_ADDR  = 0,
  localparam int unsigned ADDR_W    = $clog2(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [5:0]        i_req_op,
  input  logic [4:0]        i_req_rd,
  input  logic [4:0]        i_req_rs1,
  input  logic [4:0]        i_req_rs2,
  input  logic [31:0]       i_req_imm,
  input  logic              i_seal,
  input  logic              i_flush,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_sealed,
  output logic [1:0]        o_err
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] BASE_PTR  = PTR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] DEPTH_PTR = PTR_W'(IMEM_DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d, count_q, count_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_op_ok, enc_imm_ok, full, accept;

  rv32i_instr_encode u_encode (
    .i_op     (i_req_op),
    .i_rd     (i_req_rd),
    .i_rs1    (i_req_rs1),
    .i_rs2    (i_req_rs2),
    .i_imm    (i_req_imm),
    .o_word   (enc_word),
    .o_op_ok  (enc_op_ok),
    .o_imm_ok (enc_imm_ok)
  );

  assign full        = (ptr_q == DEPTH_PTR);
  assign o_req_ready = (state_q == ST_LOAD) & ~full & ~i_seal & ~i_flush & ~i_rst;
  assign accept      = i_req_valid & o_req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    pend_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (i_flush) begin
      state_d = ST_LOAD;
      ptr_d   = BASE_PTR;
      count_d = '0;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (i_seal) begin
            state_d = full ? ST_SEALED : ST_SEAL_WR;
          end else if (accept) begin
            if (enc_op_ok && enc_imm_ok) begin
              pend_d  = 1'b1;
              addr_d  = ptr_q[ADDR_W-1:0];
              wdata_d = enc_word;
              ptr_d   = ptr_q + PTR_W'(1);
              count_d = count_q + PTR_W'(1);
            end else if (err_q == ERR_NONE) begin
              err_d = enc_op_ok ? ERR_IMM : ERR_OP;
            end
          end
        end
        ST_SEAL_WR: begin
          pend_d  = 1'b1;
          addr_d  = ptr_q[ADDR_W-1:0];
          wdata_d = TERMINATOR;
          ptr_d   = ptr_q + PTR_W'(1);
          count_d = count_q + PTR_W'(1);
          state_d = ST_SEALED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_LOAD;
      ptr_q   <= BASE_PTR;
      count_q <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The registered write is still cancellable by reset/flush in the cycle it is presented
  assign o_imem_we    = pend_q & ~i_rst & ~i_flush;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_count      = count_q;
  assign o_full       = full;
  assign o_sealed     = (state_q == ST_SEALED);
  assign o_err        = err_q;

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Scoreboard bench for rv32i_imem_loader: a 256-word instance for encoding,
// error, seal/flush and reset behaviour, and a 4-word instance for the full limit.
module tb_rv32i_imem_loader;
  import rv32i_enc_pkg::*;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;

  logic rst = 1'b1, valid = 1'b0, seal = 1'b0, flush = 1'b0;
  logic ready, we, full, sealed;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  count;
  logic [1:0]  err;

  logic s_rst = 1'b1, s_valid = 1'b0, s_seal = 1'b0, s_flush = 1'b0;
  logic s_ready, s_we, s_full, s_sealed;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;
  logic [1:0]  s_err;

  exp_t q_main[$];
  exp_t q_small[$];
  int unsigned exp_ptr = 0, s_exp_ptr = 0;
  int n_checks = 0, n_errors = 0;

  rv32i_imem_loader #(.IMEM_DEPTH(256), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_op(req_op), .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
    .i_req_imm(req_imm), .i_seal(seal), .i_flush(flush),
    .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_count(count), .o_full(full), .o_sealed(sealed), .o_err(err)
  );

  rv32i_imem_loader #(.IMEM_DEPTH(4), .BASE_ADDR(0)) dut_small (
    .i_clk(clk), .i_rst(s_rst), .i_req_valid(s_valid), .o_req_ready(s_ready),
    .i_req_op(req_op), .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
    .i_req_imm(req_imm), .i_seal(s_seal), .i_flush(s_flush),
    .o_imem_we(s_we), .o_imem_addr(s_addr), .o_imem_wdata(s_wdata),
    .o_count(s_count), .o_full(s_full), .o_sealed(s_sealed), .o_err(s_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle; a legal one is pushed to the scoreboard
  task automatic issue(input bit sm, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input bit push, input logic [31:0] exp);
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    if (sm) begin
      s_valid = 1'b1;
      if (push) begin q_small.push_back('{s_exp_ptr, exp}); s_exp_ptr++; end
    end else begin
      valid = 1'b1;
      if (push) begin q_main.push_back('{exp_ptr, exp}); exp_ptr++; end
    end
    #1;
    check_eq(sm ? "s_ready_on_issue" : "ready_on_issue", 32'(sm ? s_ready : ready), 1);
    @(posedge clk); #1;
    valid = 1'b0;
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we) begin
      check_eq("main_sb_avail", 32'(q_main.size() != 0), 1);
      if (q_main.size() != 0) begin
        e = q_main.pop_front();
        check_eq("main_addr", 32'(addr), e.addr);
        check_eq("main_wdata", wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_we) begin
      check_eq("small_sb_avail", 32'(q_small.size() != 0), 1);
      if (q_small.size() != 0) begin
        e = q_small.pop_front();
        check_eq("small_addr", 32'(s_addr), e.addr);
        check_eq("small_wdata", s_wdata, e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_we", 32'(we), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_ready", 32'(ready), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_sealed", 32'(sealed), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(ready), 1);
    check_eq("full_after_rst", 32'(full), 0);

    // Back-to-back encodes
    issue(0, OP_ADDI, 1, 0, 0, 5, 1, 32'h0050_0093);
    issue(0, OP_ADD,  3, 1, 2, 0, 1, 32'h0020_81B3);
    @(negedge clk);
    check_eq("count_2", 32'(count), 2);
    issue(0, OP_SUB,  3, 1, 2, 0,   1, 32'h4020_81B3);
    issue(0, OP_SRAI, 5, 6, 0, 3,   1, 32'h4033_5293);
    issue(0, OP_BEQ,  0, 1, 2, 8,   1, 32'h0020_8463);
    issue(0, OP_LUI,  5, 0, 0, 32'h1234_5ABC, 1, 32'h1234_52B7);
    issue(0, OP_JAL,  1, 0, 0, 2048, 1, 32'h0010_00EF);
    issue(0, OP_SW,   0, 1, 2, -4,  1, 32'hFE20_AE23);
    issue(0, OP_BNE,  0, 1, 0, -4,  1, 32'hFE00_9EE3);
    @(negedge clk);
    check_eq("count_9", 32'(count), 9);

    // Illegal immediates: first error sticks, no write, pointer held
    issue(0, OP_ADDI, 1, 0, 0, 2048, 0, 0);
    issue(0, OP_SLLI, 1, 0, 0, 32,   0, 0);
    @(negedge clk);
    check_eq("err_imm", 32'(err), 2);
    check_eq("count_after_err", 32'(count), 9);
    issue(0, OP_ADDI, 0, 0, 0, 2047,  1, 32'h7FF0_0013);
    issue(0, OP_ADDI, 0, 0, 0, -2048, 1, 32'h8000_0013);
    @(negedge clk);
    check_eq("err_sticky", 32'(err), 2);
    check_eq("count_11", 32'(count), 11);

    // Flush cancels the pending write and clears error/count
    issue(0, OP_ADDI, 1, 0, 0, 1, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    check_eq("flush_err", 32'(err), 0);
    check_eq("flush_count", 32'(count), 0);
    check_eq("flush_ready", 32'(ready), 1);
    issue(0, 6'd63, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("err_unknown_op", 32'(err), 1);
    issue(0, OP_BEQ, 0, 1, 2, 3, 0, 0);
    @(negedge clk);
    check_eq("err_first_wins", 32'(err), 1);
    check_eq("count_odd_branch", 32'(count), 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    // Seal appends the terminator, then requests are refused until flush
    issue(0, OP_ADDI, 1, 0, 0, 5, 1, 32'h0050_0093);
    issue(0, OP_ADD,  3, 1, 2, 0, 1, 32'h0020_81B3);
    q_main.push_back('{exp_ptr, 32'h0000_006F});
    exp_ptr++;
    seal = 1'b1;
    #1;
    check_eq("ready_during_seal", 32'(ready), 0);
    @(posedge clk); #1;
    seal = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("sealed", 32'(sealed), 1);
    check_eq("sealed_ready", 32'(ready), 0);
    check_eq("sealed_count", 32'(count), 3);
    valid = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("sealed_ready_held", 32'(ready), 0);
    valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    check_eq("unseal_sealed", 32'(sealed), 0);
    check_eq("unseal_ready", 32'(ready), 1);
    check_eq("unseal_count", 32'(count), 0);
    issue(0, OP_ORI,  2, 1, 0, 255, 1, 32'h0FF0_E113);
    issue(0, OP_ANDI, 2, 1, 0, 15,  1, 32'h00F0_F113);

    // Reset the cycle after an accept: that write must never appear
    issue(0, OP_ADDI, 1, 0, 0, 7, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_cancel_we", 32'(we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    check_eq("post_rst_addr", 32'(addr), 0);
    check_eq("post_rst_wdata", wdata, 0);
    check_eq("post_rst_count", 32'(count), 0);
    check_eq("post_rst_flags", {29'b0, full, sealed, we}, 0);

    // Small IMEM: fills after four words, then stalls and seals without a write
    issue(1, OP_ADDI, 1, 0, 0, 1, 1, 32'h0010_0093);
    issue(1, OP_ADDI, 1, 0, 0, 2, 1, 32'h0020_0093);
    issue(1, OP_ADDI, 1, 0, 0, 3, 1, 32'h0030_0093);
    issue(1, OP_ADDI, 1, 0, 0, 4, 1, 32'h0040_0093);
    @(negedge clk);
    check_eq("small_full", 32'(s_full), 1);
    check_eq("small_ready_full", 32'(s_ready), 0);
    check_eq("small_count", 32'(s_count), 4);
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("small_ready_held", 32'(s_ready), 0);
    s_valid = 1'b0;
    s_seal = 1'b1;
    @(posedge clk); #1;
    s_seal = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("small_sealed", 32'(s_sealed), 1);
    check_eq("small_count_sealed", 32'(s_count), 4);
    check_eq("small_err", 32'(s_err), 0);

    repeat (3) @(negedge clk);
    check_eq("main_sb_drained", q_main.size(), 0);
    check_eq("small_sb_drained", q_small.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
